// File: rtl/regfile_dump.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_dump
//  Purpose  : Walks every entry of the register file through one of its
//             combinational read ports and streams the contents out as
//             (index, data) words on a valid/ready interface. The write port
//             of the register file is never frozen, so each word reflects the
//             register value at the moment it is read.
//  Ports    : clk       - rising-edge clock
//             reset     - asynchronous active-high reset
//             start     - dump request, honoured only while idle
//             busy      - high whenever a dump is in progress
//             ra / rd   - register-file read address / combinational data
//             out_valid - out_data/out_idx/out_last are valid
//             out_ready - sink accepts a word on out_valid & out_ready
//             out_data  - captured register value
//             out_idx   - register index of out_data
//             out_last  - marks the word for the final register
//             done      - single-cycle pulse after the last word is accepted
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_dump #(
    parameter int NREGS = 8,
    parameter int AW    = 3,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic [AW-1:0] ra,
    input  logic [DW-1:0] rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_idx,
    output logic          out_last,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [AW-1:0] c_last_idx = AW'(NREGS - 1);

    state_t        state_q,    state_d;
    logic [AW-1:0] idx_q,      idx_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [AW-1:0] out_idx_q,  out_idx_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            out_data_q <= '0;
            out_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            out_data_q <= out_data_d;
            out_idx_q  <= out_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        out_data_d = out_data_q;
        out_idx_d  = out_idx_q;
        case (state_q)
            S_IDLE: begin
                idx_d = '0;
                if (start) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                // Snapshot rd here: later writes to this register are not
                // reflected, writes to registers not yet read still are.
                out_data_d = rd;
                out_idx_d  = idx_q;
                state_d    = S_SEND;
            end
            S_SEND: begin
                if (out_ready) begin
                    if (idx_q == c_last_idx) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // All handshake outputs decode from registered state only, so there is
    // no combinational path from out_ready to out_valid/out_last/done.
    // idx_q is held at zero while idle, so it drives ra directly.
    assign busy      = (state_q != S_IDLE);
    assign ra        = idx_q;
    assign out_valid = (state_q == S_SEND);
    assign out_last  = (state_q == S_SEND) && (idx_q == c_last_idx);
    assign done      = (state_q == S_DONE);
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_dump
//  Purpose  : Directed self-checking bench for regfile_dump. A behavioural
//             8x16 register file (r0 reads as zero) answers the read port; a
//             negedge monitor collects accepted words, done pulses and any
//             change of the held word during a stall.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_dump;

    localparam int NREGS = 8;
    localparam int AW    = 3;
    localparam int DW    = 16;

    logic          clk;
    logic          reset;
    logic          start;
    logic          busy;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_idx;
    logic          out_last;
    logic          done;

    regfile_dump #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .ra        (ra),
        .rd        (rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model
    logic [DW-1:0] regs [NREGS];
    assign rd = (ra == '0) ? '0 : regs[ra];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor state
    logic [DW-1:0] got_data [$];
    logic [AW-1:0] got_idx  [$];
    logic          got_last [$];
    int            done_cnt   = 0;
    int            stall_err  = 0;
    logic          stall_pend = 1'b0;
    logic [DW-1:0] hold_data;
    logic [AW-1:0] hold_idx;
    logic          hold_last;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_pend = 1'b0;
            end else begin
                if (out_valid) begin
                    if (stall_pend && (out_data !== hold_data || out_idx !== hold_idx ||
                                       out_last !== hold_last))
                        stall_err++;
                    if (out_ready) begin
                        got_data.push_back(out_data);
                        got_idx.push_back(out_idx);
                        got_last.push_back(out_last);
                        stall_pend = 1'b0;
                    end else begin
                        stall_pend = 1'b1;
                        hold_data  = out_data;
                        hold_idx   = out_idx;
                        hold_last  = out_last;
                    end
                end else begin
                    if (stall_pend) stall_err++;
                    stall_pend = 1'b0;
                end
                if (done) done_cnt++;
            end
        end
    end

    logic [DW-1:0] exp_words [NREGS];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got_data.delete();
        got_idx.delete();
        got_last.delete();
        done_cnt  = 0;
        stall_err = 0;
    endtask

    task automatic preload();
        for (int i = 0; i < NREGS; i++) begin
            regs[i]      = 16'h1111 * i[15:0];
            exp_words[i] = (i == 0) ? 16'h0000 : 16'h1111 * i[15:0];
        end
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        check_eq({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic verify_stream(input string tag);
        check_eq({tag, "_count"}, got_data.size(), NREGS);
        for (int i = 0; i < NREGS; i++) begin
            if (i < got_data.size()) begin
                check_eq($sformatf("%s_data%0d", tag, i), {16'd0, got_data[i]}, {16'd0, exp_words[i]});
                check_eq($sformatf("%s_idx%0d", tag, i), {29'd0, got_idx[i]}, i);
                check_eq($sformatf("%s_last%0d", tag, i), {31'd0, got_last[i]}, (i == NREGS - 1) ? 1 : 0);
            end
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_busy"},  {31'd0, busy},      32'd0);
        check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check_eq({tag, "_data"},  {16'd0, out_data},  32'd0);
        check_eq({tag, "_idx"},   {29'd0, out_idx},   32'd0);
        check_eq({tag, "_last"},  {31'd0, out_last},  32'd0);
        check_eq({tag, "_done"},  {31'd0, done},      32'd0);
        check_eq({tag, "_ra"},    {29'd0, ra},        32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        preload();
        tick();
        tick();
        check_zero_outputs("reset");
        reset = 1'b0;
        tick();
        clear_mon();

        // Test 1: full dump, sink always ready, cycle-accurate timing
        out_ready = 1'b1;
        start     = 1'b1;
        tick();                         // edge 0 sampled start, now cycle 1
        start     = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            check_eq($sformatf("t1_busy_c%0d", c),  {31'd0, busy},      (c <= 17) ? 1 : 0);
            check_eq($sformatf("t1_valid_c%0d", c), {31'd0, out_valid}, (c % 2 == 0 && c <= 16) ? 1 : 0);
            check_eq($sformatf("t1_done_c%0d", c),  {31'd0, done},      (c == 17) ? 1 : 0);
            if (c % 2 == 0 && c <= 16) begin
                check_eq($sformatf("t1_data_c%0d", c), {16'd0, out_data}, {16'd0, exp_words[c/2 - 1]});
                check_eq($sformatf("t1_idx_c%0d", c),  {29'd0, out_idx},  c/2 - 1);
                check_eq($sformatf("t1_last_c%0d", c), {31'd0, out_last}, (c == 16) ? 1 : 0);
            end
            tick();
        end
        verify_stream("t1");
        check_eq("t1_done_cnt", done_cnt, 1);
        clear_mon();

        // Test 2: sink ready one cycle in three
        out_ready = 1'b0;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        for (int c = 1; c < 200 && busy; c++) begin
            out_ready = (c % 3 == 0);
            tick();
        end
        out_ready = 1'b1;
        wait_idle("t2", 10);
        tick();
        verify_stream("t2");
        check_eq("t2_stall_stable", stall_err, 0);
        check_eq("t2_done_cnt", done_cnt, 1);
        clear_mon();

        // Test 3: start re-pulsed mid-dump is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            start = (c == 5 || c == 12);
            tick();
        end
        start = 1'b0;
        verify_stream("t3");
        check_eq("t3_done_cnt", done_cnt, 1);
        check_eq("t3_busy_end", {31'd0, busy}, 32'd0);
        clear_mon();

        // Test 4: reset while idx 3 is being offered
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 8; c++) tick();   // now cycle 8: SEND idx 3
        check_eq("t4_pre_valid", {31'd0, out_valid}, 32'd1);
        check_eq("t4_pre_idx",   {29'd0, out_idx},   32'd3);
        #1 reset = 1'b1;
        #1;
        check_zero_outputs("t4_abort");
        tick();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        check_eq("t4_partial_cnt", got_data.size(), 3);
        check_eq("t4_no_done", done_cnt, 0);
        check_eq("t4_idle", {31'd0, busy}, 32'd0);
        clear_mon();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle("t4b", 40);
        tick();
        verify_stream("t4b");
        check_eq("t4b_done_cnt", done_cnt, 1);
        clear_mon();

        // Test 5: writes during SEND of idx 2
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 6; c++) tick();   // now cycle 6: SEND idx 2
        check_eq("t5_pre_idx", {29'd0, out_idx}, 32'd2);
        regs[6] = 16'hBEEF;
        regs[1] = 16'hDEAD;
        exp_words[6] = 16'hBEEF;
        wait_idle("t5", 40);
        tick();
        verify_stream("t5");
        preload();
        clear_mon();

        // Test 6: start held high -> back-to-back dumps, one idle cycle apart
        start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            check_eq($sformatf("t6_busy_c%0d", c), {31'd0, busy}, (c == 18 || c == 36) ? 0 : 1);
        end
        start = 1'b0;
        check_eq("t6_done_cnt", done_cnt, 2);
        wait_idle("t6", 40);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
